// File: rtl/if_fetch_buffer_if.sv
// Fetch-buffer bus: PC/IMEM side inputs, IF/ID head outputs, PC enable and stats.
interface if_fetch_buffer_if #(
  parameter int INSN_W = 32,
  parameter int PC_W   = 32
);
  logic [PC_W-1:0]   pc_cur;
  logic [PC_W-1:0]   pc_plus_4;
  logic [INSN_W-1:0] imem_q;
  logic              id_stall;
  logic              flush;
  logic              pc_ena;
  logic              if_id_valid;
  logic [INSN_W-1:0] if_id_insn;
  logic [PC_W-1:0]   if_id_pc;
  logic [PC_W-1:0]   if_id_pc_plus_4;
  logic [2:0]        buf_count;
  logic [31:0]       stat_fetch;
  logic [31:0]       stat_bubble;
  logic [31:0]       stat_flush;

  // slave: the buffer itself; master: the surrounding pipeline
  modport slave (
    input  pc_cur, pc_plus_4, imem_q, id_stall, flush,
    output pc_ena, if_id_valid, if_id_insn, if_id_pc, if_id_pc_plus_4,
           buf_count, stat_fetch, stat_bubble, stat_flush
  );
  modport master (
    output pc_cur, pc_plus_4, imem_q, id_stall, flush,
    input  pc_ena, if_id_valid, if_id_insn, if_id_pc, if_id_pc_plus_4,
           buf_count, stat_fetch, stat_bubble, stat_flush
  );
endinterface

// File: rtl/if_fetch_buffer.sv
// Fetch-stage buffer: tracks one in-flight IMEM read, queues {insn,pc,pc+1}, gates PC enable.
// Optional counters enabled by defining IFB_STATS_EN.
module if_fetch_buffer #(
  parameter int DEPTH  = 2,
  parameter int INSN_W = 32,
  parameter int PC_W   = 32
) (
  input logic          clock,
  input logic          reset,
  if_fetch_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [2:0]        count_q, count_d;
  logic              inflight_q;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PC_W-1:0]   tag_pc_q, tag_pc1_q;
  logic [INSN_W-1:0] insn_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [PC_W-1:0]   pc1_mem_q  [DEPTH];

  logic       valid, pop, push, issue, pc_ena;
  logic [3:0] occ;

  assign valid = (count_q != 3'd0) & reset;
  assign pop   = valid & ~bus.id_stall & ~bus.flush;
  assign push  = inflight_q & ~bus.flush;
  // Slots already promised (stored + in flight) after this cycle's pop must leave room.
  assign occ    = {1'b0, count_q} + {3'b0, inflight_q} - {3'b0, pop};
  assign pc_ena = reset & (bus.flush | (occ < 4'(DEPTH)));
  assign issue  = pc_ena & ~bus.flush;

  assign count_d = count_q + {2'b0, push} - {2'b0, pop};

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_pc_q   <= '0;
      tag_pc1_q  <= '0;
    end else if (bus.flush) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue) begin
        tag_pc_q  <= bus.pc_cur;
        tag_pc1_q <= bus.pc_plus_4;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      insn_mem_q[wr_ptr_q] <= bus.imem_q;
      pc_mem_q[wr_ptr_q]   <= tag_pc_q;
      pc1_mem_q[wr_ptr_q]  <= tag_pc1_q;
    end
  end

  assign bus.pc_ena          = pc_ena;
  assign bus.if_id_valid     = valid;
  assign bus.if_id_insn      = reset ? insn_mem_q[rd_ptr_q] : '0;
  assign bus.if_id_pc        = reset ? pc_mem_q[rd_ptr_q]   : '0;
  assign bus.if_id_pc_plus_4 = reset ? pc1_mem_q[rd_ptr_q]  : '0;
  assign bus.buf_count       = count_q;

`ifdef IFB_STATS_EN
  logic [31:0] fetch_q, bubble_q, flush_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (push)      fetch_q  <= fetch_q + 32'd1;
      if (!valid)    bubble_q <= bubble_q + 32'd1;
      if (bus.flush) flush_q  <= flush_q + 32'd1;
    end
  end

  assign bus.stat_fetch  = fetch_q;
  assign bus.stat_bubble = bubble_q;
  assign bus.stat_flush  = flush_q;
`else
  assign bus.stat_fetch  = '0;
  assign bus.stat_bubble = '0;
  assign bus.stat_flush  = '0;
`endif
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Random + directed bench for if_fetch_buffer against a queue-based fetch model.
module tb_if_fetch_buffer;
  localparam int DEPTH  = 2;
  localparam int INSN_W = 32;
  localparam int PC_W   = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] tgt = '0;

  if_fetch_buffer_if #(.INSN_W(INSN_W), .PC_W(PC_W)) bus ();

  if_fetch_buffer #(.DEPTH(DEPTH), .INSN_W(INSN_W), .PC_W(PC_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + a;
  endfunction

  // Environment: PC register with redirect mux and synchronous IMEM.
  assign bus.pc_cur    = pc_q;
  assign bus.pc_plus_4 = pc_q + 32'd1;
  always @(posedge clock) begin
    bus.imem_q <= mem_word(pc_q);
    if (!reset)          pc_q <= '0;
    else if (bus.pc_ena) pc_q <= bus.flush ? tgt : pc_q + 32'd1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: fetched PCs awaiting decode, plus at most one outstanding read.
  logic [31:0] q[$];
  bit          m_inf = 1'b0;
  logic [31:0] m_tag = '0;
  logic [31:0] stream_nxt = '0;
  logic [31:0] s_fetch = '0, s_bubble = '0, s_flush = '0;

  task automatic eval_cycle();
    bit v, pop, ena;
    chk("count", 64'(bus.buf_count), 64'(q.size()));
`ifdef IFB_STATS_EN
    chk("stat_fetch",  64'(bus.stat_fetch),  64'(s_fetch));
    chk("stat_bubble", 64'(bus.stat_bubble), 64'(s_bubble));
    chk("stat_flush",  64'(bus.stat_flush),  64'(s_flush));
`else
    chk("stat_off", {bus.stat_fetch, bus.stat_bubble | bus.stat_flush}, 64'd0);
`endif
    if (!reset) begin
      chk("rst_ena",   64'(bus.pc_ena), 64'd0);
      chk("rst_valid", 64'(bus.if_id_valid), 64'd0);
      chk("rst_head",  {bus.if_id_insn | bus.if_id_pc_plus_4, bus.if_id_pc}, 64'd0);
      q.delete();
      m_inf = 1'b0;
      stream_nxt = '0;
      s_fetch = '0; s_bubble = '0; s_flush = '0;
      return;
    end
    v   = q.size() != 0;
    pop = v && !bus.id_stall && !bus.flush;
    ena = bus.flush || (int'(q.size()) + int'(m_inf) - int'(pop) < DEPTH);
    chk("pc_ena", 64'(bus.pc_ena), 64'(ena));
    chk("valid",  64'(bus.if_id_valid), 64'(v));
    if (v) begin
      chk("head_pc",   64'(bus.if_id_pc), 64'(q[0]));
      chk("head_pc1",  64'(bus.if_id_pc_plus_4), 64'(q[0] + 32'd1));
      chk("head_insn", 64'(bus.if_id_insn), 64'(mem_word(q[0])));
    end
    if (pop) begin
      chk("order", 64'(bus.if_id_pc), 64'(stream_nxt));
      stream_nxt = bus.if_id_pc + 32'd1;
    end
    if (bus.flush) s_flush++;
    if (!v) s_bubble++;
    if (m_inf && !bus.flush) s_fetch++;
    if (bus.flush) begin
      q.delete();
      m_inf = 1'b0;
      stream_nxt = tgt;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_inf) q.push_back(m_tag);
      m_inf = ena;
      m_tag = pc_q;
    end
  endtask

  task automatic step(input bit r, input bit st, input bit fl, input logic [31:0] t);
    @(negedge clock);
    reset        = r;
    bus.id_stall = st;
    bus.flush    = fl;
    tgt          = t;
    #1;
    eval_cycle();
  endtask

  initial begin
    bus.id_stall = 1'b0;
    bus.flush    = 1'b0;
    @(posedge clock);
    repeat (3)  step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4)  step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6)  step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2)  step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h40);
    repeat (6)  step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3)  step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h80);
    repeat (5)  step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3)  step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2)  step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (8)  step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 5,
           32'($urandom_range(0, 1023)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
